// File: rtl/eye_scan_monitor_if.sv
// eye_scan_monitor_if: sweep control, sample feed and result bus
// between the eye scanner and its consumer.
interface eye_scan_monitor_if #(
  parameter int PHASE_W = 4
);
  logic               start;
  logic               ack;
  real                threshold;
  real                sample;
  logic [PHASE_W-1:0] phase_sel;
  logic               busy;
  logic               phase_result_valid;
  logic [PHASE_W-1:0] phase_result_phase;
  real                phase_result_opening;
  logic               done;
  logic [PHASE_W-1:0] best_phase;
  real                best_opening;

  modport master (
    output start, ack, threshold, sample,
    input  phase_sel, busy, phase_result_valid,
    input  phase_result_phase, phase_result_opening,
    input  done, best_phase, best_opening
  );

  modport slave (
    input  start, ack, threshold, sample,
    output phase_sel, busy, phase_result_valid,
    output phase_result_phase, phase_result_opening,
    output done, best_phase, best_opening
  );
endinterface

// File: rtl/eye_scan_monitor.sv
// eye_scan_monitor: sweeps the sampling phase, bins samples per phase
// and reports each eye opening plus the best phase of the sweep.
module eye_scan_monitor #(
  parameter int SAMPLE_COUNT  = 100,
  parameter int NUM_PHASES    = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int MODE          = 0,
  parameter int PHASE_W       =
    (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input logic clock,
  input logic reset,
  eye_scan_monitor_if.slave bus
);
  localparam int MAXC = (SAMPLE_COUNT > SETTLE_CYCLES) ?
                        SAMPLE_COUNT : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_ACCUM  = 3'd2;
  localparam logic [2:0] S_EVAL   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FIRST  =
    (SETTLE_CYCLES > 0) ? S_SETTLE : S_ACCUM;

  localparam logic [CNT_W-1:0] LAST_SMP =
    CNT_W'(SAMPLE_COUNT - 1);
  localparam logic [CNT_W-1:0] LAST_SET =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [PHASE_W-1:0] LAST_PH =
    PHASE_W'(NUM_PHASES - 1);
  localparam real BIG = 1.0e300;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_high;
  logic [CNT_W-1:0] cnt_low;
  real              sum_high;
  real              sum_low;
  real              min_high;
  real              max_low;
  real              opening;
  logic             hit;

  assign hit = bus.sample >= bus.threshold;
  assign bus.busy = (state == S_SETTLE) ||
                    (state == S_ACCUM)  ||
                    (state == S_EVAL);

  // an empty bin means no eye was seen at this phase
  always_comb begin
    opening = 0.0;
    if (cnt_high != '0 && cnt_low != '0) begin
      if (MODE == 1) begin
        opening = min_high - max_low;
        if (opening < 0.0) opening = 0.0;
      end else begin
        opening = sum_high / real'(cnt_high)
                - sum_low / real'(cnt_low);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                    <= S_IDLE;
      cnt                      <= '0;
      cnt_high                 <= '0;
      cnt_low                  <= '0;
      sum_high                 <= 0.0;
      sum_low                  <= 0.0;
      min_high                 <= BIG;
      max_low                  <= -BIG;
      bus.phase_sel            <= '0;
      bus.phase_result_valid   <= 1'b0;
      bus.phase_result_phase   <= '0;
      bus.phase_result_opening <= 0.0;
      bus.done                 <= 1'b0;
      bus.best_phase           <= '0;
      bus.best_opening         <= 0.0;
    end else begin
      bus.phase_result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state            <= S_FIRST;
            cnt              <= '0;
            bus.phase_sel    <= '0;
            bus.best_phase   <= '0;
            bus.best_opening <= -1.0;
          end
        end
        S_SETTLE: begin
          if (cnt == LAST_SET) begin
            cnt   <= '0;
            state <= S_ACCUM;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_ACCUM: begin
          if (hit) begin
            sum_high <= sum_high + bus.sample;
            cnt_high <= cnt_high + CNT_W'(1);
            if (bus.sample < min_high) min_high <= bus.sample;
          end else begin
            sum_low <= sum_low + bus.sample;
            cnt_low <= cnt_low + CNT_W'(1);
            if (bus.sample > max_low) max_low <= bus.sample;
          end
          if (cnt == LAST_SMP) begin
            cnt   <= '0;
            state <= S_EVAL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_EVAL: begin
          bus.phase_result_valid   <= 1'b1;
          bus.phase_result_phase   <= bus.phase_sel;
          bus.phase_result_opening <= opening;
          // strict compare keeps the lowest phase on ties
          if (opening > bus.best_opening) begin
            bus.best_opening <= opening;
            bus.best_phase   <= bus.phase_sel;
          end
          cnt_high <= '0;
          cnt_low  <= '0;
          sum_high <= 0.0;
          sum_low  <= 0.0;
          min_high <= BIG;
          max_low  <= -BIG;
          if (bus.phase_sel == LAST_PH) begin
            state    <= S_DONE;
            bus.done <= 1'b1;
          end else begin
            bus.phase_sel <= bus.phase_sel + PHASE_W'(1);
            state         <= S_FIRST;
          end
        end
        S_DONE: begin
          if (bus.ack) begin
            state    <= S_IDLE;
            bus.done <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
